dbg_chan_mux: RTL

- Multi-channel debug bytestream multiplexer. It sits between the SoC's debug sources/sinks and a single host-facing debug byte channel (the one driven by the verilated TB or a UART bridge).
- Merges NCH device-side TX streams into one tagged host TX stream using per-channel FIFOs and burst-limited round-robin arbitration.
- Demultiplexes a tagged host RX stream into NCH per-channel RX FIFOs and flags overflow.

---
 rtl/dbg_chan_mux.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dbg_chan_mux.sv
// -----------------------------------------------------------------------------
// dbg_chan_mux
//
// Multi-channel debug bytestream multiplexer between NCH device-side debug
// channels and one host-facing byte channel.
//
//   TX direction: each device channel pushes bytes into its own FIFO. A
//   burst-limited round-robin arbiter selects one FIFO. The selected FIFO
//   head is loaded into a registered output stage tagged with the channel
//   number.
//   RX direction: tagged host bytes are steered into per-channel FIFOs. A
//   byte that arrives for a full FIFO is dropped and raises a sticky
//   overflow flag.
//
// Handshake (every has_data/consume pair in this block):
//   A byte moves in any cycle where has_data and consume are both 1. The
//   consumer only asserts consume while has_data is 1. has_data and the data
//   bus stay stable until the byte is consumed.
//
// Ports:
//   clk               in   clock
//   reset_n           in   asynchronous active-low reset
//   ch_tx_data        in   NCH*W device TX bytes, channel i at [i*W +: W]
//   ch_tx_has_data    in   NCH   device channel i offers a byte
//   ch_tx_consume     out  NCH   block accepts channel i's byte this cycle
//   ch_rx_data        out  NCH*W head byte of RX FIFO i
//   ch_rx_has_data    out  NCH   RX FIFO i not empty
//   ch_rx_consume     in   NCH   device pops RX FIFO i
//   host_tx_data      out  W     registered output byte
//   host_tx_chan      out  clog2(NCH) source channel of host_tx_data
//   host_tx_has_data  out  1     output register valid
//   host_tx_consume   in   1     host takes the byte
//   host_rx_data      in   W     incoming host byte
//   host_rx_chan      in   clog2(NCH) destination channel
//   host_rx_produce   in   1     host writes a byte
//   host_rx_has_space out  1     RX FIFO[host_rx_chan] not full (combinational)
//   rx_overflow       out  NCH   sticky per-channel drop flag
//   ovf_clear         in   1     clears all rx_overflow bits
// -----------------------------------------------------------------------------
module dbg_chan_mux #(
    parameter int NCH   = 4,
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NCH*W-1:0]         ch_tx_data,
    input  logic [NCH-1:0]           ch_tx_has_data,
    output logic [NCH-1:0]           ch_tx_consume,
    output logic [NCH*W-1:0]         ch_rx_data,
    output logic [NCH-1:0]           ch_rx_has_data,
    input  logic [NCH-1:0]           ch_rx_consume,
    output logic [W-1:0]             host_tx_data,
    output logic [$clog2(NCH)-1:0]   host_tx_chan,
    output logic                     host_tx_has_data,
    input  logic                     host_tx_consume,
    input  logic [W-1:0]             host_rx_data,
    input  logic [$clog2(NCH)-1:0]   host_rx_chan,
    input  logic                     host_rx_produce,
    output logic                     host_rx_has_space,
    output logic [NCH-1:0]           rx_overflow,
    input  logic                     ovf_clear
);

    localparam int CW = $clog2(NCH);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(BURST + 1);

    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);
    localparam logic [CW-1:0] RR_INIT   = CW'(NCH - 1);

    // -------------------------------------------------------------------------
    // TX FIFOs (device -> block)
    // -------------------------------------------------------------------------
    logic [W-1:0]   r_tx_mem [NCH][DEPTH];
    logic [AW:0]    r_tx_wp  [NCH];
    logic [AW:0]    r_tx_rp  [NCH];

    logic [NCH-1:0] w_tx_full;
    logic [NCH-1:0] w_tx_empty;
    logic [NCH-1:0] w_tx_push;
    logic [NCH-1:0] w_tx_pop;
    logic [W-1:0]   w_tx_head [NCH];

    // Output stage and arbiter state
    logic [W-1:0]   r_out_data;
    logic [CW-1:0]  r_out_chan;
    logic           r_out_valid;
    logic [CW-1:0]  r_rr_ptr;
    logic [BW-1:0]  r_burst;

    logic           w_load;
    logic           w_keep;
    logic           w_rot_vld;
    logic [CW-1:0]  w_rot_ch;
    logic           w_grant_vld;
    logic [CW-1:0]  w_grant;

    // FIFO status is taken from registered pointers only, so a push into an
    // empty FIFO is seen by the arbiter one cycle later and a full FIFO does
    // not accept a byte even if it is popped in the same cycle.
    always_comb begin
        w_tx_empty = '0;
        w_tx_full  = '0;
        w_tx_push  = '0;
        w_tx_head  = '{default: '0};
        for (int i = 0; i < NCH; i++) begin
            w_tx_empty[i] = (r_tx_wp[i] == r_tx_rp[i]);
            w_tx_full[i]  = (r_tx_wp[i][AW] != r_tx_rp[i][AW]) &&
                            (r_tx_wp[i][AW-1:0] == r_tx_rp[i][AW-1:0]);
            w_tx_head[i]  = r_tx_mem[i][r_tx_rp[i][AW-1:0]];
            w_tx_push[i]  = ch_tx_has_data[i] & ~w_tx_full[i];
        end
    end

    assign ch_tx_consume = w_tx_push;

    // The output register can take a new byte when it is empty or when its
    // current byte leaves this cycle, giving one byte per cycle.
    assign w_load = ~r_out_valid | host_tx_consume;

    // Arbiter. r_burst == 0 only after reset and means "no previous grant",
    // so the sticky path is disabled and the rotating search starting after
    // RR_INIT (NCH-1) gives channel 0 first priority.
    always_comb begin
        w_keep    = (r_burst != '0) && (r_burst < BURST_MAX) && !w_tx_empty[r_rr_ptr];
        w_rot_vld = 1'b0;
        w_rot_ch  = '0;
        for (int k = 1; k <= NCH; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!w_rot_vld && (i == ((int'(r_rr_ptr) + k) % NCH)) && !w_tx_empty[i]) begin
                    w_rot_vld = 1'b1;
                    w_rot_ch  = CW'(i);
                end
            end
        end
        w_grant_vld = w_keep | w_rot_vld;
        w_grant     = w_keep ? r_rr_ptr : w_rot_ch;
    end

    always_comb begin
        w_tx_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            w_tx_pop[i] = w_load & w_grant_vld & (w_grant == CW'(i));
        end
    end

    // FIFO storage carries no reset: clearing the pointers discards contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (w_tx_push[i]) begin
                r_tx_mem[i][r_tx_wp[i][AW-1:0]] <= ch_tx_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_tx_wp[i] <= '0;
                r_tx_rp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_tx_push[i]) begin
                    r_tx_wp[i] <= r_tx_wp[i] + PTR_ONE;
                end
                if (w_tx_pop[i]) begin
                    r_tx_rp[i] <= r_tx_rp[i] + PTR_ONE;
                end
            end
        end
    end

    // Output register plus arbiter state; both advance only on load cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= RR_INIT;
            r_burst     <= '0;
        end else if (w_load) begin
            if (w_grant_vld) begin
                r_out_data  <= w_tx_head[w_grant];
                r_out_chan  <= w_grant;
                r_out_valid <= 1'b1;
                r_rr_ptr    <= w_grant;
                // Repeat grants count up (saturating once the limit forces a
                // rotation that finds no other channel); a new channel
                // restarts the burst.
                if ((w_grant == r_rr_ptr) && (r_burst != '0)) begin
                    if (r_burst != BURST_MAX) begin
                        r_burst <= r_burst + BURST_ONE;
                    end
                end else begin
                    r_burst <= BURST_ONE;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign host_tx_data     = r_out_data;
    assign host_tx_chan     = r_out_chan;
    assign host_tx_has_data = r_out_valid;

    // -------------------------------------------------------------------------
    // RX FIFOs (host -> device)
    // -------------------------------------------------------------------------
    logic [W-1:0]   r_rx_mem [NCH][DEPTH];
    logic [AW:0]    r_rx_wp  [NCH];
    logic [AW:0]    r_rx_rp  [NCH];
    logic [NCH-1:0] r_ovf;

    logic [NCH-1:0] w_rx_full;
    logic [NCH-1:0] w_rx_empty;
    logic [NCH-1:0] w_rx_sel;
    logic [NCH-1:0] w_rx_push;
    logic [NCH-1:0] w_rx_pop;
    logic [NCH-1:0] w_ovf_set;

    always_comb begin
        w_rx_empty = '0;
        w_rx_full  = '0;
        ch_rx_data = '0;
        for (int i = 0; i < NCH; i++) begin
            w_rx_empty[i] = (r_rx_wp[i] == r_rx_rp[i]);
            w_rx_full[i]  = (r_rx_wp[i][AW] != r_rx_rp[i][AW]) &&
                            (r_rx_wp[i][AW-1:0] == r_rx_rp[i][AW-1:0]);
            ch_rx_data[i*W +: W] = r_rx_mem[i][r_rx_rp[i][AW-1:0]];
        end
    end

    // A channel number >= NCH selects no FIFO: no space, no push, no flag.
    always_comb begin
        w_rx_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            w_rx_sel[i] = (host_rx_chan == CW'(i));
        end
        host_rx_has_space = |(w_rx_sel & ~w_rx_full);
        w_rx_push = {NCH{host_rx_produce}} & w_rx_sel & ~w_rx_full;
        w_ovf_set = {NCH{host_rx_produce}} & w_rx_sel &  w_rx_full;
        w_rx_pop  = ch_rx_consume & ~w_rx_empty;
    end

    assign ch_rx_has_data = ~w_rx_empty;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (w_rx_push[i]) begin
                r_rx_mem[i][r_rx_wp[i][AW-1:0]] <= host_rx_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_rx_wp[i] <= '0;
                r_rx_rp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_rx_push[i]) begin
                    r_rx_wp[i] <= r_rx_wp[i] + PTR_ONE;
                end
                if (w_rx_pop[i]) begin
                    r_rx_rp[i] <= r_rx_rp[i] + PTR_ONE;
                end
            end
        end
    end

    // A drop in the same cycle as a clear must remain visible, so the set
    // term is applied after the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~{NCH{ovf_clear}}) | w_ovf_set;
        end
    end

    assign rx_overflow = r_ovf;

endmodule
